led_display_pattern_gen: RTL and testbench

//  Test-pattern source for the 64x32 HUB75-style LED panel. It generates a stream of
//  rgb_row_t row-pair words (top/bot half, R/G/B, 64 px each) with a 4-bit row address.

---
 rtl/led_display_pattern_gen.sv | 179 +++++++++++++++++
 tb/tb_led_display_pattern_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/led_display_pattern_gen.sv
// Test-pattern source for a 64x32 HUB75 panel: streams row-pair words over valid/ready.
// Optional LED_PTG_SCAN_H_EN adds a horizontal-bar scan mode (mode 4).
module led_display_pattern_gen #(
  parameter int unsigned SYS_CLK_FREQ = 100_000_000,
  parameter bit          SIMULATION   = 1'b0
) (
  input  logic         clk_in,
  input  logic         reset_in,
  input  logic [2:0]   colour_in,
  input  logic [3:0]   mode_in,
  output logic [383:0] row_out,
  output logic         row_valid_out,
  input  logic         row_ready_in,
  output logic [3:0]   row_address_out
);

  localparam int unsigned GL_NUM_COL_PIXELS = 64;
  localparam int unsigned STEP_CYC  = SIMULATION ? 100 : SYS_CLK_FREQ / 100;
  localparam int unsigned PULSE_CYC = SIMULATION ? 64  : SYS_CLK_FREQ / 512;
  localparam int unsigned STEP_W    = (STEP_CYC > 1)  ? $clog2(STEP_CYC)  : 1;
  localparam int unsigned PULSE_W   = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEP_CYC - 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_CYC - 1);

  typedef enum logic [3:0] {
    MODE_OFF    = 4'd0,
    MODE_SOLID  = 4'd1,
    MODE_SCAN_V = 4'd2,
    MODE_PULSE  = 4'd3
`ifdef LED_PTG_SCAN_H_EN
    , MODE_SCAN_H = 4'd4
`endif
  } mode_e;

  typedef struct packed {
    logic [GL_NUM_COL_PIXELS-1:0] red;
    logic [GL_NUM_COL_PIXELS-1:0] green;
    logic [GL_NUM_COL_PIXELS-1:0] blue;
  } rgb_half_t;

  typedef struct packed {
    rgb_half_t top;
    rgb_half_t bot;
  } rgb_row_t;

  mode_e                  mode_reg, mode_prev;
  logic [2:0]             colour_reg;
  logic [STEP_W-1:0]      step_cnt;
  logic [5:0]             scan_col;
  logic [PULSE_W-1:0]     pulse_cnt;
  logic [7:0]             duty;
  logic                   duty_up;
  logic [7:0]             pwm_cnt;
`ifdef LED_PTG_SCAN_H_EN
  logic [3:0]             scan_row;
  logic [3:0]             row_eff;
`endif

  rgb_row_t               row_q, pat;
  logic                   valid_q;
  logic [3:0]             addr_q, addr_next;
  logic                   mode_change, fire, load;
  logic [5:0]             col_eff;
  logic [7:0]             duty_eff, pwm_eff;
  logic [GL_NUM_COL_PIXELS-1:0] col_mask;
  rgb_half_t              half;

  assign row_out         = row_q;
  assign row_valid_out   = valid_q;
  assign row_address_out = addr_q;

  // On a mode change the counters clear in the same edge the new beat is loaded,
  // so the pattern is built from the cleared values rather than the stale ones.
  always_comb begin
    mode_change = (mode_reg != mode_prev);
    fire        = valid_q & row_ready_in;
    load        = mode_change | ~valid_q | fire;
    addr_next   = (mode_change | ~valid_q) ? 4'd0 : addr_q + 4'd1;
    col_eff     = mode_change ? 6'd0 : scan_col;
    duty_eff    = mode_change ? 8'd0 : duty;
    pwm_eff     = mode_change ? 8'd0 : pwm_cnt;
`ifdef LED_PTG_SCAN_H_EN
    row_eff     = mode_change ? 4'd0 : scan_row;
`endif
    col_mask    = '0;
    case (mode_reg)
      MODE_SOLID:  col_mask = '1;
      MODE_SCAN_V: col_mask = GL_NUM_COL_PIXELS'(1) << col_eff;
      MODE_PULSE:  col_mask = (pwm_eff < duty_eff) ? '1 : '0;
`ifdef LED_PTG_SCAN_H_EN
      MODE_SCAN_H: col_mask = (addr_next == row_eff) ? '1 : '0;
`endif
      default:     col_mask = '0;
    endcase
    half.red   = col_mask & {GL_NUM_COL_PIXELS{colour_reg[0]}};
    half.green = col_mask & {GL_NUM_COL_PIXELS{colour_reg[1]}};
    half.blue  = col_mask & {GL_NUM_COL_PIXELS{colour_reg[2]}};
    pat.top    = half;
    pat.bot    = half;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      mode_reg   <= MODE_OFF;
      mode_prev  <= MODE_OFF;
      colour_reg <= '0;
      step_cnt   <= '0;
      scan_col   <= '0;
      pulse_cnt  <= '0;
      duty       <= '0;
      duty_up    <= 1'b1;
      pwm_cnt    <= '0;
`ifdef LED_PTG_SCAN_H_EN
      scan_row   <= '0;
`endif
      row_q      <= '0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
    end else begin
      mode_reg   <= mode_e'(mode_in);
      colour_reg <= colour_in;
      mode_prev  <= mode_reg;

      if (mode_change) begin
        step_cnt  <= '0;
        scan_col  <= '0;
        pulse_cnt <= '0;
        duty      <= '0;
        duty_up   <= 1'b1;
        pwm_cnt   <= '0;
`ifdef LED_PTG_SCAN_H_EN
        scan_row  <= '0;
`endif
      end else begin
        if (step_cnt == STEP_LAST) begin
          step_cnt <= '0;
          scan_col <= scan_col + 6'd1;
`ifdef LED_PTG_SCAN_H_EN
          scan_row <= scan_row + 4'd1;
`endif
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end

        // Triangle ramp: 0..255 then 254..0, reversing at each end.
        if (pulse_cnt == PULSE_LAST) begin
          pulse_cnt <= '0;
          if (duty_up) begin
            if (duty == 8'hFF) begin
              duty_up <= 1'b0;
              duty    <= 8'hFE;
            end else begin
              duty <= duty + 8'd1;
            end
          end else begin
            if (duty == 8'h00) begin
              duty_up <= 1'b1;
              duty    <= 8'h01;
            end else begin
              duty <= duty - 8'd1;
            end
          end
        end else begin
          pulse_cnt <= pulse_cnt + 1'b1;
        end

        if (fire && (addr_q == 4'd15))
          pwm_cnt <= pwm_cnt + 8'd1;
      end

      if (load) begin
        row_q   <= pat;
        addr_q  <= addr_next;
        valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_display_pattern_gen.sv
// Directed bench for led_display_pattern_gen (SIMULATION=1 timebases).
module tb_led_display_pattern_gen;

  logic         clk_in = 1'b0;
  logic         reset_in;
  logic [2:0]   colour_in;
  logic [3:0]   mode_in;
  logic [383:0] row_out;
  logic         row_valid_out;
  logic         row_ready_in;
  logic [3:0]   row_address_out;

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;

  led_display_pattern_gen #(
    .SYS_CLK_FREQ (100_000_000),
    .SIMULATION   (1'b1)
  ) dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .colour_in       (colour_in),
    .mode_in         (mode_in),
    .row_out         (row_out),
    .row_valid_out   (row_valid_out),
    .row_ready_in    (row_ready_in),
    .row_address_out (row_address_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Row word layout, MSB first: top.red, top.green, top.blue, bot.red, bot.green, bot.blue.
  function automatic logic [383:0] mk_row(input logic [2:0] c, input logic [63:0] mask);
    logic [191:0] h;
    h = {mask & {64{c[0]}}, mask & {64{c[1]}}, mask & {64{c[2]}}};
    return {h, h};
  endfunction

  function automatic logic [63:0] col_bit(input int unsigned c);
    logic [63:0] m;
    m = 64'd1 << c;
    return m;
  endfunction

  logic [3:0]   a0;
  logic [383:0] r0;

  initial begin
    reset_in     = 1'b1;
    mode_in      = 4'd0;
    colour_in    = 3'd0;
    row_ready_in = 1'b1;
    tick(3);
    check_eq("rst_valid", row_valid_out, 0);
    check_eq("rst_addr",  row_address_out, 0);
    check_eq("rst_row",   row_out, 0);

    // OFF stream after reset: addresses 0..9, all data zero
    reset_in = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      tick(1);
      check_eq("off_valid", row_valid_out, 1);
      check_eq("off_addr",  row_address_out, i);
      check_eq("off_row",   row_out, 0);
    end

    // SOLID: mode change restarts address; colour changes leave address running
    mode_in   = 4'd1;
    colour_in = 3'd3;
    tick(2);
    check_eq("solid_addr0", row_address_out, 0);
    check_eq("solid_row3",  row_out, mk_row(3'd3, '1));
    for (int unsigned c = 0; c < 8; c++) begin
      a0        = row_address_out;
      colour_in = 3'(c);
      tick(2);
      check_eq("solid_row",  row_out, mk_row(3'(c), '1));
      check_eq("solid_addr", row_address_out, 4'(a0 + 4'd2));
      tick(8);
    end

    // Backpressure: hold data/address, ignore colour change until resumed
    a0           = row_address_out;
    r0           = row_out;
    row_ready_in = 1'b0;
    colour_in    = 3'd2;
    for (int unsigned i = 0; i < 5; i++) begin
      tick(1);
      check_eq("hold_valid", row_valid_out, 1);
      check_eq("hold_addr",  row_address_out, a0);
      check_eq("hold_row",   row_out, r0);
    end
    row_ready_in = 1'b1;
    tick(1);
    check_eq("resume_addr", row_address_out, 4'(a0 + 4'd1));
    check_eq("resume_row",  row_out, mk_row(3'd2, '1));

    // Wrap sequence over 40 beats after switching to OFF
    mode_in = 4'd0;
    tick(2);
    for (int unsigned j = 0; j < 40; j++) begin
      check_eq("wrap_addr", row_address_out, j % 16);
      check_eq("wrap_row",  row_out, 0);
      tick(1);
    end

    // Unused mode values show nothing
    mode_in   = 4'd1;
    colour_in = 3'd7;
    tick(4);
    check_eq("pre_bad_row", row_out, mk_row(3'd7, '1));
    mode_in = 4'd9;
    tick(2);
    check_eq("mode9_row",  row_out, 0);
    check_eq("mode9_addr", row_address_out, 0);
    mode_in = 4'd4;
    tick(2);
`ifdef LED_PTG_SCAN_H_EN
    check_eq("mode4_row", row_out, mk_row(3'd7, '1));
    tick(1);
    check_eq("mode4_row1", row_out, 0);
`else
    check_eq("mode4_row", row_out, 0);
`endif

    // SCAN_V: column steps every 100 cycles, wraps after 6400
    mode_in   = 4'd2;
    colour_in = 3'd1;
    tick(2);
    check_eq("scan_c0_start", row_out, mk_row(3'd1, col_bit(0)));
    tick(50);
    check_eq("scan_c0", row_out, mk_row(3'd1, col_bit(0)));
    tick(100);
    check_eq("scan_c1", row_out, mk_row(3'd1, col_bit(1)));
    tick(3100);
    check_eq("scan_c32", row_out, mk_row(3'd1, col_bit(32)));
    tick(3200);
    check_eq("scan_wrap", row_out, mk_row(3'd1, col_bit(0)));

    // PULSE: lit iff pwm (beats/16 mod 256) < duty (triangle, step 64)
    mode_in   = 4'd3;
    colour_in = 3'd2;
    tick(2);
    check_eq("pulse_k0", row_out, 0);
    tick(8);
    check_eq("pulse_k8", row_out, 0);
    tick(992);
    check_eq("pulse_k1000_off", row_out, 0);
    tick(3296);
    check_eq("pulse_k4296_on", row_out, mk_row(3'd2, '1));
    tick(21312);
    check_eq("pulse_fall_on", row_out, mk_row(3'd2, '1));
    tick(6400);
    check_eq("pulse_fall_off", row_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
    $finish;
  end

endmodule
